// File: rtl/id_ex_reg_if.sv
// ID/EX pipeline register bundle: ID-side decode fields in, EX-side registered fields out.
// The slave modport is the pipeline register; the master modport is the ID/EX stage logic around it.
// flush_i/hold_i steer the register; stall_o asks the front end to freeze PC and IF/ID.
interface id_ex_reg_if;
  // decode controls from ID
  logic        regwrite_i;
  logic        alusrc_i;
  logic        regdst_i;
  logic        memtoreg_i;
  logic        memwrite_i;
  logic        ma3d_i;
  logic        maluout_i;
  logic [2:0]  aluc_i;
  // operands and indices from ID
  logic [31:0] rd1_i;
  logic [31:0] rd2_i;
  logic [31:0] imm_i;
  logic [31:0] pc8_i;
  logic [4:0]  rs_i;
  logic [4:0]  rt_i;
  logic [4:0]  rd_i;
  // pipeline steering
  logic        flush_i;
  logic        hold_i;
  // registered EX-side view
  logic        regwrite_o;
  logic        alusrc_o;
  logic        memtoreg_o;
  logic        memwrite_o;
  logic        maluout_o;
  logic [2:0]  aluc_o;
  logic [31:0] rd1_o;
  logic [31:0] rd2_o;
  logic [31:0] imm_o;
  logic [31:0] pc8_o;
  logic [4:0]  rs_o;
  logic [4:0]  rt_o;
  logic [4:0]  wreg_o;
  logic        valid_o;
  logic        stall_o;
  logic [15:0] bubble_cnt_o;

  modport master (
    output regwrite_i, alusrc_i, regdst_i, memtoreg_i, memwrite_i, ma3d_i, maluout_i,
    output aluc_i, rd1_i, rd2_i, imm_i, pc8_i, rs_i, rt_i, rd_i, flush_i, hold_i,
    input  regwrite_o, alusrc_o, memtoreg_o, memwrite_o, maluout_o, aluc_o,
    input  rd1_o, rd2_o, imm_o, pc8_o, rs_o, rt_o, wreg_o, valid_o, stall_o, bubble_cnt_o
  );

  modport slave (
    input  regwrite_i, alusrc_i, regdst_i, memtoreg_i, memwrite_i, ma3d_i, maluout_i,
    input  aluc_i, rd1_i, rd2_i, imm_i, pc8_i, rs_i, rt_i, rd_i, flush_i, hold_i,
    output regwrite_o, alusrc_o, memtoreg_o, memwrite_o, maluout_o, aluc_o,
    output rd1_o, rd2_o, imm_o, pc8_o, rs_o, rt_o, wreg_o, valid_o, stall_o, bubble_cnt_o
  );
endinterface

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with bubble insertion, saturating bubble counter, optional load-use stall (HAZARD_DETECT_EN).
// Latency: one clk from ID inputs to EX outputs; stall_o is combinational from EX state and ID indices.
// Backpressure: hold_i freezes the slot; flush_i or a load-use stall loads a bubble (flush wins over hold).
module id_ex_reg (
  input  logic         clk,
  input  logic         rst_n,
  id_ex_reg_if.slave   bus
);

  typedef struct packed {
    logic        regwrite;
    logic        alusrc;
    logic        memtoreg;
    logic        memwrite;
    logic        maluout;
    logic [2:0]  aluc;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [31:0] pc8;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  wreg;
    logic        valid;
  } ex_slot_t;

  ex_slot_t    slot_q;
  ex_slot_t    slot_d;
  ex_slot_t    capture;
  logic        load_bubble;
  logic        stall;
  logic [15:0] bubble_cnt_q;

  // Build the slot a normal load would capture; destination chosen here so EX sees a resolved index.
  always_comb begin
    capture          = '0;
    capture.regwrite = bus.regwrite_i;
    capture.alusrc   = bus.alusrc_i;
    capture.memtoreg = bus.memtoreg_i;
    capture.memwrite = bus.memwrite_i;
    capture.maluout  = bus.maluout_i;
    capture.aluc     = bus.aluc_i;
    capture.rd1      = bus.rd1_i;
    capture.rd2      = bus.rd2_i;
    capture.imm      = bus.imm_i;
    capture.pc8      = bus.pc8_i;
    capture.rs       = bus.rs_i;
    capture.rt       = bus.rt_i;
    if (bus.ma3d_i) begin
      capture.wreg = 5'd31;
    end else if (bus.regdst_i) begin
      capture.wreg = bus.rd_i;
    end else begin
      capture.wreg = bus.rt_i;
    end
    capture.valid    = 1'b1;
  end

`ifdef HAZARD_DETECT_EN
  // Load in EX whose destination feeds the instruction in ID: freeze the front end for one bubble.
  always_comb begin
    stall = 1'b0;
    if (!bus.flush_i && !bus.hold_i && slot_q.valid && slot_q.memtoreg &&
        slot_q.regwrite && (slot_q.wreg != 5'd0) &&
        ((slot_q.wreg == bus.rs_i) || (slot_q.wreg == bus.rt_i))) begin
      stall = 1'b1;
    end
  end
`else
  // Without hazard detection the only bubble source is flush_i.
  assign stall = 1'b0;
`endif

  // Per-edge priority: flush, then hold, then load-use bubble, then normal capture.
  always_comb begin
    slot_d      = slot_q;
    load_bubble = 1'b0;
    if (bus.flush_i) begin
      slot_d      = '0;
      load_bubble = 1'b1;
    end else if (bus.hold_i) begin
      slot_d      = slot_q;
    end else if (stall) begin
      slot_d      = '0;
      load_bubble = 1'b1;
    end else begin
      slot_d      = capture;
    end
  end

  // EX slot register; reset discards any held or stalled contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

  // Count every inserted bubble, sticking at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_cnt_q <= '0;
    end else if (load_bubble && (bubble_cnt_q != 16'hFFFF)) begin
      bubble_cnt_q <= bubble_cnt_q + 16'd1;
    end
  end

  assign bus.regwrite_o   = slot_q.regwrite;
  assign bus.alusrc_o     = slot_q.alusrc;
  assign bus.memtoreg_o   = slot_q.memtoreg;
  assign bus.memwrite_o   = slot_q.memwrite;
  assign bus.maluout_o    = slot_q.maluout;
  assign bus.aluc_o       = slot_q.aluc;
  assign bus.rd1_o        = slot_q.rd1;
  assign bus.rd2_o        = slot_q.rd2;
  assign bus.imm_o        = slot_q.imm;
  assign bus.pc8_o        = slot_q.pc8;
  assign bus.rs_o         = slot_q.rs;
  assign bus.rt_o         = slot_q.rt;
  assign bus.wreg_o       = slot_q.wreg;
  assign bus.valid_o      = slot_q.valid;
  assign bus.stall_o      = stall;
  assign bus.bubble_cnt_o = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_reg.sv
// Scoreboard bench for id_ex_reg: directed vectors push expected EX state, a monitor pops and compares after each edge.
// Covers reset, decode capture, wreg selection, flush/hold priority, hold freeze, load-use stall, async reset, counter saturation.
module tb_id_ex_reg;

  typedef struct packed {
    logic        regwrite;
    logic        alusrc;
    logic        memtoreg;
    logic        memwrite;
    logic        maluout;
    logic [2:0]  aluc;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [31:0] pc8;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  wreg;
    logic        valid;
    logic [15:0] bubble_cnt;
  } out_t;

  typedef struct packed {
    logic        regwrite;
    logic        alusrc;
    logic        regdst;
    logic        memtoreg;
    logic        memwrite;
    logic        ma3d;
    logic        maluout;
    logic [2:0]  aluc;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [31:0] pc8;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
  } in_t;

  typedef struct {
    string name;
    out_t  v;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  id_ex_reg_if bus();

  id_ex_reg dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic out_t sample();
    out_t o;
    o.regwrite   = bus.regwrite_o;
    o.alusrc     = bus.alusrc_o;
    o.memtoreg   = bus.memtoreg_o;
    o.memwrite   = bus.memwrite_o;
    o.maluout    = bus.maluout_o;
    o.aluc       = bus.aluc_o;
    o.rd1        = bus.rd1_o;
    o.rd2        = bus.rd2_o;
    o.imm        = bus.imm_o;
    o.pc8        = bus.pc8_o;
    o.rs         = bus.rs_o;
    o.rt         = bus.rt_o;
    o.wreg       = bus.wreg_o;
    o.valid      = bus.valid_o;
    o.bubble_cnt = bus.bubble_cnt_o;
    return o;
  endfunction

  // expected EX state for a normal capture of v
  function automatic out_t cap(input in_t v, input logic [15:0] cnt);
    out_t o;
    o.regwrite   = v.regwrite;
    o.alusrc     = v.alusrc;
    o.memtoreg   = v.memtoreg;
    o.memwrite   = v.memwrite;
    o.maluout    = v.maluout;
    o.aluc       = v.aluc;
    o.rd1        = v.rd1;
    o.rd2        = v.rd2;
    o.imm        = v.imm;
    o.pc8        = v.pc8;
    o.rs         = v.rs;
    o.rt         = v.rt;
    o.wreg       = v.ma3d ? 5'd31 : (v.regdst ? v.rd : v.rt);
    o.valid      = 1'b1;
    o.bubble_cnt = cnt;
    return o;
  endfunction

  function automatic out_t bub(input logic [15:0] cnt);
    out_t o;
    o = '0;
    o.bubble_cnt = cnt;
    return o;
  endfunction

  task automatic chk_out(input string nm, input out_t act, input out_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk_bit(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", nm, act, exp);
    end
  endtask

  task automatic apply(input in_t v, input logic fl, input logic hd);
    bus.regwrite_i = v.regwrite;
    bus.alusrc_i   = v.alusrc;
    bus.regdst_i   = v.regdst;
    bus.memtoreg_i = v.memtoreg;
    bus.memwrite_i = v.memwrite;
    bus.ma3d_i     = v.ma3d;
    bus.maluout_i  = v.maluout;
    bus.aluc_i     = v.aluc;
    bus.rd1_i      = v.rd1;
    bus.rd2_i      = v.rd2;
    bus.imm_i      = v.imm;
    bus.pc8_i      = v.pc8;
    bus.rs_i       = v.rs;
    bus.rt_i       = v.rt;
    bus.rd_i       = v.rd;
    bus.flush_i    = fl;
    bus.hold_i     = hd;
  endtask

  // drive one ID-stage vector at the falling edge and optionally register what EX must show after the next rise
  task automatic drive(input in_t v, input logic fl, input logic hd, input bit push,
                       input string nm, input out_t e);
    exp_t x;
    @(negedge clk);
    apply(v, fl, hd);
    if (push) begin
      x.name = nm;
      x.v    = e;
      q.push_back(x);
    end
  endtask

  // monitor: one expectation per rising edge while any are pending
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        chk_out(x.name, sample(), x.v);
      end
    end
  end

  initial begin
    in_t  v, addu, jal, lw, use_v, alu8, hb, hc;
    out_t e;
    out_t z;
    logic [15:0] bc;
    int guard;

    z  = '0;
    bc = 16'd0;

    // reset with live, non-zero inputs on the bus
    rst_n = 1'b0;
    addu = '0;
    addu.regwrite = 1'b1; addu.regdst = 1'b1; addu.aluc = 3'b010;
    addu.rd1 = 32'h11; addu.rd2 = 32'h22; addu.pc8 = 32'h3004;
    addu.rs = 5'd1; addu.rt = 5'd2; addu.rd = 5'd5;
    apply(addu, 1'b0, 1'b0);
    #1;
    chk_out("reset_now", sample(), z);
    chk_bit("reset_stall", bus.stall_o, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk_out("reset_clocked", sample(), z);
    @(negedge clk);
    rst_n = 1'b1;

    // ADDU: rd-destination R-type
    e = '0;
    e.regwrite = 1'b1; e.aluc = 3'b010; e.rd1 = 32'h11; e.rd2 = 32'h22;
    e.pc8 = 32'h3004; e.rs = 5'd1; e.rt = 5'd2; e.wreg = 5'd5; e.valid = 1'b1;
    drive(addu, 1'b0, 1'b0, 1'b1, "addu", e);

    // JAL: link register forced to 31 even with rd/rt non-zero
    jal = '0;
    jal.regwrite = 1'b1; jal.ma3d = 1'b1; jal.maluout = 1'b1;
    jal.pc8 = 32'h3008; jal.imm = 32'h0c00; jal.rt = 5'd4; jal.rd = 5'd3;
    e = '0;
    e.regwrite = 1'b1; e.maluout = 1'b1; e.pc8 = 32'h3008; e.imm = 32'h0c00;
    e.rt = 5'd4; e.wreg = 5'd31; e.valid = 1'b1;
    drive(jal, 1'b0, 1'b0, 1'b1, "jal", e);

    // I-type: rt destination
    v = '0;
    v.regwrite = 1'b1; v.alusrc = 1'b1; v.aluc = 3'b001; v.rd1 = 32'hdead_0001;
    v.imm = 32'hffff_fff0; v.rs = 5'd3; v.rt = 5'd9; v.rd = 5'd7;
    e = '0;
    e.regwrite = 1'b1; e.alusrc = 1'b1; e.aluc = 3'b001; e.rd1 = 32'hdead_0001;
    e.imm = 32'hffff_fff0; e.rs = 5'd3; e.rt = 5'd9; e.wreg = 5'd9; e.valid = 1'b1;
    drive(v, 1'b0, 1'b0, 1'b1, "itype_rt", e);

    // ma3d beats regdst
    v = '0;
    v.regwrite = 1'b1; v.regdst = 1'b1; v.ma3d = 1'b1; v.rd = 5'd6; v.rt = 5'd2; v.memwrite = 1'b1;
    e = '0;
    e.regwrite = 1'b1; e.memwrite = 1'b1; e.rt = 5'd2; e.wreg = 5'd31; e.valid = 1'b1;
    drive(v, 1'b0, 1'b0, 1'b1, "ma3d_over_regdst", e);

    // NOP is a real instruction, not a bubble
    v = '0;
    v.rd1 = 32'h0000_00aa; v.pc8 = 32'h3010;
    e = '0;
    e.rd1 = 32'h0000_00aa; e.pc8 = 32'h3010; e.valid = 1'b1;
    drive(v, 1'b0, 1'b0, 1'b1, "nop_valid", e);

    // plain flush
    bc = 16'd1;
    drive(addu, 1'b1, 1'b0, 1'b1, "flush", bub(bc));

    // flush and hold together: flush wins
    drive(addu, 1'b0, 1'b0, 1'b1, "reload", cap(addu, bc));
    bc = 16'd2;
    drive(jal, 1'b1, 1'b1, 1'b1, "flush_hold", bub(bc));

    // hold for three edges with changing inputs
    hb = '0;
    hb.regwrite = 1'b1; hb.memtoreg = 1'b1; hb.alusrc = 1'b1; hb.aluc = 3'b100;
    hb.rd1 = 32'h1234_5678; hb.imm = 32'h40; hb.rs = 5'd10; hb.rt = 5'd11; hb.rd = 5'd12;
    drive(hb, 1'b0, 1'b0, 1'b1, "pre_hold", cap(hb, bc));
    drive(addu, 1'b0, 1'b1, 1'b1, "hold1", cap(hb, bc));
    drive(jal, 1'b0, 1'b1, 1'b1, "hold2", cap(hb, bc));
    hc = addu; hc.rd1 = 32'hffff_ffff; hc.rs = 5'd31;
    drive(hc, 1'b0, 1'b1, 1'b1, "hold3", cap(hb, bc));

    // load-use: lw writes $8, next instruction reads $8 through rs
    lw = '0;
    lw.regwrite = 1'b1; lw.memtoreg = 1'b1; lw.alusrc = 1'b1; lw.aluc = 3'b010;
    lw.rd1 = 32'h1000; lw.imm = 32'h4; lw.rs = 5'd29; lw.rt = 5'd8;
    use_v = '0;
    use_v.regwrite = 1'b1; use_v.regdst = 1'b1; use_v.aluc = 3'b010;
    use_v.rs = 5'd8; use_v.rt = 5'd9; use_v.rd = 5'd10;
    drive(lw, 1'b0, 1'b0, 1'b1, "lw", cap(lw, bc));
`ifdef HAZARD_DETECT_EN
    bc = bc + 16'd1;
    drive(use_v, 1'b0, 1'b0, 1'b1, "load_use_bubble", bub(bc));
    #1;
    chk_bit("stall_load_use", bus.stall_o, 1'b1);
`else
    drive(use_v, 1'b0, 1'b0, 1'b1, "load_use_nohaz", cap(use_v, bc));
    #1;
    chk_bit("stall_tied_low", bus.stall_o, 1'b0);
`endif
    // hold and flush both mask the stall request
    drive(lw, 1'b0, 1'b0, 1'b1, "lw_again", cap(lw, bc));
    drive(use_v, 1'b0, 1'b1, 1'b1, "use_held", cap(lw, bc));
    #1;
    chk_bit("stall_masked_hold", bus.stall_o, 1'b0);
    bc = bc + 16'd1;
    drive(use_v, 1'b1, 1'b0, 1'b1, "use_flushed", bub(bc));
    #1;
    chk_bit("stall_masked_flush", bus.stall_o, 1'b0);

    // ALU result (not a load) to $8 followed by a reader: no stall in either build
    alu8 = '0;
    alu8.regwrite = 1'b1; alu8.regdst = 1'b1; alu8.aluc = 3'b010; alu8.rd = 5'd8;
    drive(alu8, 1'b0, 1'b0, 1'b1, "alu8", cap(alu8, bc));
    drive(use_v, 1'b0, 1'b0, 1'b1, "no_stall_alu", cap(use_v, bc));
    #1;
    chk_bit("stall_non_load", bus.stall_o, 1'b0);

    // async reset in the middle of a hold
    drive(hb, 1'b0, 1'b0, 1'b1, "pre_rst_hold", cap(hb, bc));
    drive(addu, 1'b0, 1'b1, 1'b1, "rst_hold1", cap(hb, bc));
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("reset_mid_hold", sample(), z);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_out("held_after_reset", sample(), z);
    bc = 16'd0;
    drive(jal, 1'b0, 1'b0, 1'b1, "first_after_reset", cap(jal, bc));

    // saturation: 65535 flushes reach 0xFFFF, the next one sticks
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    for (int i = 1; i <= 65536; i++) begin
      drive(addu, 1'b1, 1'b0, (i >= 65534), "sat_cnt",
            bub((i > 65535) ? 16'hFFFF : 16'(i)));
    end

    guard = 0;
    while ((q.size() > 0) && (guard < 10)) begin
      @(posedge clk);
      #2;
      guard++;
    end
    if (q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_ex_reg.md
ID_EX_REG -- requirements
Module: id_ex_reg

Interface
REQ-001 SHALL have port clk, input, 1, single rising-edge clock for all state.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have inputs regwrite_i, alusrc_i, regdst_i, memtoreg_i, memwrite_i, ma3d_i, maluout_i, each input, 1, decode control bits for the instruction in ID.
REQ-004 SHALL have input aluc_i, 3, decoded ALU operation.
REQ-005 SHALL have inputs rd1_i, rd2_i, imm_i, pc8_i, each input, 32, register-file read data, extended immediate, return address.
REQ-006 SHALL have inputs rs_i, rt_i, rd_i, each input, 5, instruction register indices.
REQ-007 SHALL have input flush_i, 1, kill the instruction entering EX (taken branch/jump).
REQ-008 SHALL have input hold_i, 1, freeze EX contents (downstream stall).
REQ-009 SHALL have outputs regwrite_o, alusrc_o, memtoreg_o, memwrite_o, maluout_o, each output, 1; aluc_o, output, 3: registered controls.
REQ-010 SHALL have outputs rd1_o, rd2_o, imm_o, pc8_o, each output, 32; rs_o, rt_o, wreg_o, each output, 5: registered data/indices.
REQ-011 SHALL have output valid_o, 1, EX slot holds a real instruction.
REQ-012 SHALL have output stall_o, 1, combinational request to freeze PC and IF/ID (load-use).
REQ-013 SHALL have output bubble_cnt_o, 16, count of bubbles inserted.

Function
REQ-014 SHALL update all registered outputs only on rising clk; one-cycle latency ID->EX.
REQ-015 SHALL compute wreg_o at capture: 31 if ma3d_i=1, else rd_i if regdst_i=1, else rt_i.
REQ-016 SHALL apply per-edge priority: flush_i > hold_i > stall_o bubble > normal load.
REQ-017 SHALL on flush_i=1 load a bubble: every control output 0, aluc_o=0, valid_o=0, all data/index outputs 0, regardless of hold_i.
REQ-018 SHALL on hold_i=1 (flush_i=0) retain every output and bubble_cnt_o unchanged.
REQ-019 SHALL on stall_o=1 (flush_i=0, hold_i=0) load a bubble identical to REQ-017.
REQ-020 SHALL otherwise capture all inputs and set valid_o=1.
REQ-021 SHALL increment bubble_cnt_o by 1 on every edge loading a bubble (REQ-017, REQ-019), saturating at 16'hFFFF.
REQ-022 SHALL treat a NOP (all control inputs 0) as a normal load with valid_o=1, not counted as a bubble.

Reset
REQ-023 SHALL on rst_n=0 immediately clear all outputs to 0 (valid_o=0, bubble_cnt_o=0), independent of clk.
REQ-024 SHALL resume normal capture on the first rising clk after rst_n deasserts; reset mid-hold or mid-stall discards the held state.

Configuration
REQ-025 SHALL compile load-use detection only when macro HAZARD_DETECT_EN is defined.
REQ-026 SHALL with HAZARD_DETECT_EN drive stall_o=1 when valid_o=1, memtoreg_o=1, regwrite_o=1, wreg_o!=0, and wreg_o equals rs_i or rt_i; else 0.
REQ-027 SHALL with HAZARD_DETECT_EN gate stall_o with hold_i=0 and flush_i=0 (stall_o=0 when either asserted).
REQ-028 SHALL without HAZARD_DETECT_EN tie stall_o to 0; bubbles arise only from flush_i.

Verification
REQ-029 SHALL cover: ADDU decode inputs, rd_i=5, regdst_i=1 -> next edge regwrite_o=1, aluc_o=3'b010, wreg_o=5, valid_o=1.
REQ-030 SHALL cover: JAL inputs (ma3d_i=1, pc8_i=0x3008) -> wreg_o=31, pc8_o=0x3008, maluout_o=1.
REQ-031 SHALL cover: LW in EX with wreg_o=8, ID rs_i=8 (HAZARD_DETECT_EN) -> stall_o=1, next edge valid_o=0, bubble_cnt_o=1.
REQ-032 SHALL cover: flush_i=1 and hold_i=1 same edge -> bubble loaded, bubble_cnt_o increments.
REQ-033 SHALL cover: hold_i=1 for 3 cycles with changing inputs -> all outputs constant; rst_n=0 mid-hold -> outputs 0 immediately.
REQ-034 SHALL cover: bubble_cnt_o preloaded to 0xFFFF by 65535 flushes, one more flush -> remains 0xFFFF.
